// File: rtl/cache_way_select_if.sv
// cache_way_select_if: request/response channel plus the PLRU update and victim ports of the way-select stage
interface cache_way_select_if #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8,
  parameter int WAY_W   = 2
);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_hit;
  logic [WAY_W-1:0]   rsp_way;
  logic               rsp_evict;
  logic               rsp_evict_dirty;
  logic [TAG_W-1:0]   rsp_evict_tag;
  logic               plru_upd_valid;
  logic [INDEX_W-1:0] plru_upd_index;
  logic [WAY_W-1:0]   plru_upd_way;
  logic               plru_vic_req;
  logic [INDEX_W-1:0] plru_vic_index;
  logic [WAY_W-1:0]   plru_vic_way;
  modport slave (
    input  req_valid, req_write, req_index, req_tag, rsp_ready, plru_vic_way,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_dirty, rsp_evict_tag,
    output plru_upd_valid, plru_upd_index, plru_upd_way, plru_vic_req, plru_vic_index
  );
  modport master (
    output req_valid, req_write, req_index, req_tag, rsp_ready, plru_vic_way,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_dirty, rsp_evict_tag,
    input  plru_upd_valid, plru_upd_index, plru_upd_way, plru_vic_req, plru_vic_index
  );
endinterface

// File: rtl/cache_way_select.sv
// cache_way_select: 4-way tag/valid/dirty lookup feeding a tree-PLRU; WAYSEL_STATS_EN adds hit/miss/evict counters
module cache_way_select #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8,
  parameter int WAYS    = 4,
  parameter int WAY_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_way_select_if.slave   bus
`ifdef WAYSEL_STATS_EN
  ,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt,
  output logic [15:0]         evict_cnt
`endif
);
  localparam int SETS = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, LOOKUP, VICTIM, RESP} state_t;
  state_t                                  r_state;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]    r_tags;
  logic [SETS-1:0][WAYS-1:0]               r_valid;
  logic [SETS-1:0][WAYS-1:0]               r_dirty;
  logic                                    r_write;
  logic [INDEX_W-1:0]                      r_index;
  logic [TAG_W-1:0]                        r_tag;
  logic                                    r_req_ready;
  logic                                    r_rsp_valid;
  logic                                    r_rsp_hit;
  logic [WAY_W-1:0]                        r_rsp_way;
  logic                                    r_rsp_evict;
  logic                                    r_rsp_evict_dirty;
  logic [TAG_W-1:0]                        r_rsp_evict_tag;
  logic                                    r_upd_valid;
  logic [WAY_W-1:0]                        r_upd_way;
  logic                                    r_vic_req;
  logic [WAYS-1:0]                         w_match;
  logic [WAY_W-1:0]                        w_hit_way;
  logic [WAY_W-1:0]                        w_free_way;
  logic                                    w_hit;
  logic                                    w_free;
  always_comb begin
    w_match = '0;
    for (int i = 0; i < WAYS; i++)
      w_match[i] = r_valid[r_index][i] && (r_tags[r_index][i] == r_tag);
  end
  // Scan downwards so the lowest-numbered candidate is the one left standing.
  always_comb begin
    w_hit_way  = '0;
    w_free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_way = WAY_W'(i);
      if (!r_valid[r_index][i]) w_free_way = WAY_W'(i);
    end
  end
  assign w_hit  = |w_match;
  assign w_free = ~&r_valid[r_index];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_tags            <= '0;
      r_valid           <= '0;
      r_dirty           <= '0;
      r_write           <= 1'b0;
      r_index           <= '0;
      r_tag             <= '0;
      r_req_ready       <= 1'b1;
      r_rsp_valid       <= 1'b0;
      r_rsp_hit         <= 1'b0;
      r_rsp_way         <= '0;
      r_rsp_evict       <= 1'b0;
      r_rsp_evict_dirty <= 1'b0;
      r_rsp_evict_tag   <= '0;
      r_upd_valid       <= 1'b0;
      r_upd_way         <= '0;
      r_vic_req         <= 1'b0;
    end else begin
      r_upd_valid <= 1'b0;
      r_vic_req   <= 1'b0;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_write     <= bus.req_write;
          r_index     <= bus.req_index;
          r_tag       <= bus.req_tag;
          r_req_ready <= 1'b0;
          r_state     <= LOOKUP;
        end
        LOOKUP: if (w_hit) begin
          if (r_write) r_dirty[r_index][w_hit_way] <= 1'b1;
          r_rsp_hit   <= 1'b1;
          r_rsp_way   <= w_hit_way;
          r_upd_valid <= 1'b1;
          r_upd_way   <= w_hit_way;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end else if (w_free) begin
          r_valid[r_index][w_free_way] <= 1'b1;
          r_dirty[r_index][w_free_way] <= r_write;
          r_tags[r_index][w_free_way]  <= r_tag;
          r_rsp_way   <= w_free_way;
          r_upd_valid <= 1'b1;
          r_upd_way   <= w_free_way;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end else begin
          r_vic_req <= 1'b1;
          r_state   <= VICTIM;
        end
        // The PLRU block advances itself on a victim request, so no update pulse here.
        VICTIM: begin
          r_rsp_evict       <= 1'b1;
          r_rsp_evict_dirty <= r_dirty[r_index][bus.plru_vic_way];
          r_rsp_evict_tag   <= r_tags[r_index][bus.plru_vic_way];
          r_rsp_way         <= bus.plru_vic_way;
          r_valid[r_index][bus.plru_vic_way] <= 1'b1;
          r_dirty[r_index][bus.plru_vic_way] <= r_write;
          r_tags[r_index][bus.plru_vic_way]  <= r_tag;
          r_rsp_valid       <= 1'b1;
          r_state           <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          r_rsp_valid       <= 1'b0;
          r_rsp_hit         <= 1'b0;
          r_rsp_way         <= '0;
          r_rsp_evict       <= 1'b0;
          r_rsp_evict_dirty <= 1'b0;
          r_rsp_evict_tag   <= '0;
          r_req_ready       <= 1'b1;
          r_state           <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready       = r_req_ready;
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_hit         = r_rsp_hit;
  assign bus.rsp_way         = r_rsp_way;
  assign bus.rsp_evict       = r_rsp_evict;
  assign bus.rsp_evict_dirty = r_rsp_evict_dirty;
  assign bus.rsp_evict_tag   = r_rsp_evict_tag;
  assign bus.plru_upd_valid  = r_upd_valid;
  assign bus.plru_upd_index  = r_index;
  assign bus.plru_upd_way    = r_upd_way;
  assign bus.plru_vic_req    = r_vic_req;
  assign bus.plru_vic_index  = r_index;
`ifdef WAYSEL_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic [15:0] r_evict_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_evict_cnt <= '0;
    end else begin
      if (r_state == LOOKUP && w_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (r_state == LOOKUP && !w_hit && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
      if (r_state == VICTIM && r_evict_cnt != 16'hFFFF) r_evict_cnt <= r_evict_cnt + 16'd1;
    end
  end
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign evict_cnt = r_evict_cnt;
`endif
endmodule

// File: tb/tb_cache_way_select.sv
// tb_cache_way_select: directed vectors with hand-computed expectations for cache_way_select
module tb_cache_way_select;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  always #5 clk = ~clk;
  cache_way_select_if #(.INDEX_W(4), .TAG_W(8), .WAY_W(2)) bus ();
`ifdef WAYSEL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, evict_cnt;
  cache_way_select dut (.clk(clk), .rst_n(rst_n), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt));
`else
  cache_way_select dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic txn(input logic w, input logic [3:0] idx, input logic [7:0] tg, input logic [1:0] vw,
                     input logic e_hit, input logic [1:0] e_way, input logic e_ev, input logic e_dirty,
                     input logic [7:0] e_etag, input int hold);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_index = idx;
    bus.req_tag = tg;
    bus.plru_vic_way = vw;
    step();
    bus.req_valid = 1'b0;
    check("lk_ready", bus.req_ready, 0);
    check("lk_rsp", bus.rsp_valid, 0);
    step();
    if (e_ev) begin
      check("vic_req", bus.plru_vic_req, 1);
      check("vic_idx", bus.plru_vic_index, idx);
      check("vic_upd", bus.plru_upd_valid, 0);
      check("vic_rsp", bus.rsp_valid, 0);
      step();
      check("ev_upd", bus.plru_upd_valid, 0);
      check("ev_vic", bus.plru_vic_req, 0);
    end else begin
      check("upd_valid", bus.plru_upd_valid, 1);
      check("upd_idx", bus.plru_upd_index, idx);
      check("upd_way", bus.plru_upd_way, e_way);
      check("upd_vic", bus.plru_vic_req, 0);
    end
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_hit", bus.rsp_hit, e_hit);
    check("rsp_way", bus.rsp_way, e_way);
    check("rsp_evict", bus.rsp_evict, e_ev);
    check("rsp_edirty", bus.rsp_evict_dirty, e_dirty);
    check("rsp_etag", bus.rsp_evict_tag, e_etag);
    for (int k = 0; k < hold; k++) begin
      bus.req_valid = 1'b1;
      bus.req_tag = tg ^ 8'hFF;
      step();
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_ready", bus.req_ready, 0);
      check("hold_way", bus.rsp_way, e_way);
      check("hold_etag", bus.rsp_evict_tag, e_etag);
      check("hold_upd", bus.plru_upd_valid, 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("idle_ready", bus.req_ready, 1);
    check("idle_rsp", bus.rsp_valid, 0);
    check("idle_hit", bus.rsp_hit, 0);
    check("idle_evict", bus.rsp_evict, 0);
    check("idle_way", bus.rsp_way, 0);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_index = '0;
    bus.req_tag = '0;
    bus.rsp_ready = 1'b0;
    bus.plru_vic_way = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", bus.req_ready, 1);
    check("rst_rsp", bus.rsp_valid, 0);
    check("rst_upd", bus.plru_upd_valid, 0);
    check("rst_vic", bus.plru_vic_req, 0);
    txn(0, 4'd3, 8'h11, 2'd0, 0, 2'd0, 0, 0, 8'h00, 0);
    txn(0, 4'd3, 8'h11, 2'd0, 1, 2'd0, 0, 0, 8'h00, 0);
    txn(1, 4'd3, 8'h11, 2'd0, 1, 2'd0, 0, 0, 8'h00, 0);
    txn(0, 4'd3, 8'h22, 2'd0, 0, 2'd1, 0, 0, 8'h00, 0);
    txn(0, 4'd3, 8'h33, 2'd0, 0, 2'd2, 0, 0, 8'h00, 0);
    txn(0, 4'd3, 8'h44, 2'd0, 0, 2'd3, 0, 0, 8'h00, 0);
    txn(0, 4'd3, 8'h55, 2'd0, 0, 2'd0, 1, 1, 8'h11, 5);
`ifdef WAYSEL_STATS_EN
    check("hit_cnt", hit_cnt, 2);
    check("miss_cnt", miss_cnt, 5);
    check("evict_cnt", evict_cnt, 1);
`endif
    txn(0, 4'd3, 8'h11, 2'd2, 0, 2'd2, 1, 0, 8'h33, 0);
    txn(1, 4'd3, 8'h22, 2'd0, 1, 2'd1, 0, 0, 8'h00, 0);
    txn(0, 4'd3, 8'h66, 2'd1, 0, 2'd1, 1, 1, 8'h22, 0);
    txn(0, 4'd0, 8'h22, 2'd0, 0, 2'd0, 0, 0, 8'h00, 0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_index = 4'd3;
    bus.req_tag = 8'h77;
    bus.plru_vic_way = 2'd3;
    step();
    bus.req_valid = 1'b0;
    step();
    check("abort_vic", bus.plru_vic_req, 1);
    rst_n = 1'b0;
    #1;
    check("abort_rsp", bus.rsp_valid, 0);
    check("abort_ready", bus.req_ready, 1);
    check("abort_vic_clr", bus.plru_vic_req, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rsp", bus.rsp_valid, 0);
    txn(0, 4'd3, 8'h55, 2'd3, 0, 2'd0, 0, 0, 8'h00, 0);
    txn(0, 4'd3, 8'h44, 2'd3, 0, 2'd1, 0, 0, 8'h00, 0);
    txn(0, 4'd0, 8'h22, 2'd3, 0, 2'd0, 0, 0, 8'h00, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cache_way_select.md
Name: cache_way_select

Overview:
- Tag/valid/dirty lookup stage sitting directly upstream of the 4-way tree-PLRU replacement block in the cache controller.
- Accepts one request at a time (index, tag, read/write) and compares the tag against all ways of the set.
- Resolves hit, miss-with-free-way or miss-with-eviction.
- Drives the PLRU block's update and victim-request interfaces and returns way plus eviction info to the controller FSM.

Parameters:
- INDEX_W, 4, set index width (SETS = 2**INDEX_W)
- TAG_W, 8, tag width
- WAYS, 4, associativity; fixed at 4 to match the 3-bit PLRU tree
- WAY_W, 2, way number width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_write  in  1  1 = write access, 0 = read
- req_index  in  INDEX_W  set index
- req_tag  in  TAG_W  tag
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  controller consumes response
- rsp_hit  out  1  1 = hit
- rsp_way  out  WAY_W  hit way or way that was filled
- rsp_evict  out  1  a valid line was replaced
- rsp_evict_dirty  out  1  replaced line was dirty (writeback needed)
- rsp_evict_tag  out  TAG_W  tag of replaced line
- plru_upd_valid  out  1  one-cycle pulse: mark plru_upd_way most recently used
- plru_upd_index  out  INDEX_W  set for the update
- plru_upd_way  out  WAY_W  way for the update
- plru_vic_req  out  1  one-cycle pulse: request victim (PLRU block updates itself)
- plru_vic_index  out  INDEX_W  set for the victim request
- plru_vic_way  in  WAY_W  victim way, valid in the same cycle as plru_vic_req

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE
  - all valid and dirty bits cleared; tag contents don't-care
  - all outputs 0 except req_ready = 1 once in IDLE
  - reset mid-operation aborts the request with no response and no array write
- States: IDLE, LOOKUP, VICTIM, RESP.
- IDLE:
  - req_ready = 1
  - on req_valid, latch write/index/tag and go to LOOKUP
- LOOKUP (1 cycle): compare the latched tag against all 4 ways' (valid && tag).
  - Hit:
    - rsp_hit = 1, rsp_way = hit way
    - pulse plru_upd for the hit way
    - write sets that way's dirty bit; read leaves dirty unchanged
    - go to RESP
  - Miss with any invalid way:
    - fill the lowest-numbered invalid way: valid = 1, tag = req tag, dirty = req_write
    - pulse plru_upd for the filled way
    - rsp_evict = 0
    - go to RESP
  - Miss with all ways valid: go to VICTIM.
- VICTIM (1 cycle):
  - assert plru_vic_req and sample plru_vic_way
  - capture the old tag and dirty bit into rsp_evict_tag / rsp_evict_dirty; rsp_evict = 1
  - overwrite the way: tag = req tag, valid = 1, dirty = req_write
  - no plru_upd pulse
  - go to RESP
- RESP:
  - rsp_valid = 1 and all rsp_* fields stable until rsp_ready
  - on rsp_ready, return to IDLE
  - rsp_* fields clear to 0 in IDLE
- Latency from acceptance edge: hit or free-way fill gives rsp_valid 2 cycles later; eviction gives 3 cycles.
- Throughput: one request in flight; req_ready is low from LOOKUP through the RESP handshake.
- Multiple matching ways cannot occur by construction; if they do, the lowest-numbered way wins.
- plru_upd_valid and plru_vic_req are never high in the same cycle.

Optional Feature:
- Macro: WAYSEL_STATS_EN
- Defined: adds outputs hit_cnt, miss_cnt and evict_cnt, each 16 bits.
  - Each counter saturates at 16'hFFFF.
  - hit_cnt and miss_cnt increment in LOOKUP; evict_cnt increments in VICTIM.
  - All cleared by rst_n.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- After reset, read index 3 tag 8'h11 -> 2 cycles later: rsp_hit = 0, rsp_way = 0, rsp_evict = 0; plru_upd pulse (index 3, way 0).
- Repeat read index 3 tag 8'h11 -> rsp_hit = 1, rsp_way = 0; plru_upd way 0; then write to it sets dirty.
- Fill index 3 with tags 8'h11, 8'h22, 8'h33, 8'h44 (8'h11 written), then read tag 8'h55 with plru_vic_way = 0 -> plru_vic_req pulse in cycle 2; rsp at cycle 3 with rsp_evict = 1, rsp_evict_dirty = 1, rsp_evict_tag = 8'h11, rsp_way = 0.
- Hold rsp_ready low for 5 cycles -> rsp fields stable, req_ready = 0, a new req_valid is ignored; rsp_ready = 1 -> IDLE next cycle.
- Assert rst_n low during VICTIM -> no response; subsequent lookup of any prior tag misses with rsp_evict = 0.
- With WAYSEL_STATS_EN: 2 hits, 5 misses, 1 evict -> hit_cnt = 2, miss_cnt = 5, evict_cnt = 1.
